axi4lite_master_param: RTL and testbench

Parametrised AXI4-Lite master; successor to the fixed 2-bit-address / 8-bit-data master.
- Generalises address/data width and adds per-byte write strobes.
- Issues AW and W concurrently, holds VALID until READY (AXI-compliant), and reports BRESP/RRESP to the user.
- Sits between the user command logic and the AXI4-Lite slave fabric. Single outstanding transaction.

---
 rtl/axi4lite_pkg.sv | 26 ++
 rtl/axi4lite_watchdog.sv | 34 +++
 rtl/axi4lite_master_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi4lite_master_param.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the parametrised AXI4-Lite master: response codes,
// FSM state encoding and parameter legality helpers.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_RESP = 3'd2,
        RD_AR   = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    function automatic bit data_w_legal(input int width);
        return (width == 8) || (width == 16) || (width == 32) || (width == 64);
    endfunction

    function automatic bit addr_w_legal(input int width);
        return (width >= 1) && (width <= 32);
    endfunction

endpackage

// File: rtl/axi4lite_watchdog.sv
// Transaction watchdog for the AXI4-Lite master; only built when AXI4L_TIMEOUT_EN
// is defined, since the master instantiates it only in that configuration.
`ifdef AXI4L_TIMEOUT_EN
module axi4lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of busy cycles already elapsed, so the cycle in
    // which it equals LIMIT is the TIMEOUT_CYCLES-th busy cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == LIMIT);

endmodule
`endif

// File: rtl/axi4lite_master_param.sv
// Parametrised AXI4-Lite master: single outstanding transaction, AW and W issued together.
// Define AXI4L_TIMEOUT_EN to add the watchdog abort (SLVERR + rsp_timeout).
module axi4lite_master_param
    import axi4lite_pkg::*;
#(
    parameter int  ADDR_W         = 8,
    parameter int  DATA_W         = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("axi4lite_master_param: DATA_W must be 8, 16, 32 or 64");
    end
    if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
        $error("axi4lite_master_param: ADDR_W must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4lite_master_param: TIMEOUT_CYCLES must be >= 2");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_resp;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_expired;
    logic w_abort;

    assign w_accept  = req_valid && r_req_ready;
    assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_w_hs    = m_axi_wvalid && m_axi_wready;
    assign w_b_hs    = m_axi_bvalid && m_axi_bready;
    assign w_ar_hs   = m_axi_arvalid && m_axi_arready;
    assign w_r_hs    = m_axi_rvalid && m_axi_rready;
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A completing handshake takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (w_aw_done && w_w_done) begin
                    w_next_state = WR_RESP;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            RD_AR: begin
                if (w_ar_hs) begin
                    w_next_state = RD_DATA;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (w_r_hs) begin
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_abort) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_req_ready <= 1'b1;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            r_req_ready <= (w_next_state == IDLE);
            if (w_accept) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    // Response stage: one-cycle pulse after B/R handshake or watchdog abort.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_rsp_valid <= 1'b0;
            r_resp      <= RESP_OKAY;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_b_hs) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= m_axi_bresp;
            end else if (w_r_hs) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= m_axi_rresp;
                r_rdata     <= m_axi_rdata;
            end else if (w_abort) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= RESP_SLVERR;
            end
        end
    end

`ifdef AXI4L_TIMEOUT_EN
    logic r_rsp_timeout;

    axi4lite_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (m_axi_aclk),
        .i_rst_n   (m_axi_aresetn),
        .i_clr     (w_accept),
        .i_en      (busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_abort;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_expired   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready     = r_req_ready;
    assign busy          = (r_state != IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_err       = r_rsp_valid && r_resp[1];

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = (r_state == WR_AW_W) && !r_aw_done;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = (r_state == WR_AW_W) && !r_w_done;
    assign m_axi_bready  = (r_state == WR_RESP);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = (r_state == RD_AR);
    assign m_axi_rready  = (r_state == RD_DATA);

endmodule

// File: tb/tb_axi4lite_master_param.sv
// Scoreboard bench for axi4lite_master_param: random requests against a memory-backed
// slave model, with directed latency, skew, back-to-back, reset and watchdog cases.
module tb_axi4lite_master_param;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int TO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [STRB_W-1:0] req_wstrb = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready = 1'b0;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [STRB_W-1:0] m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready = 1'b0;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 1'b0;
    logic [DATA_W-1:0] m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = 2'b00;
    logic              m_axi_rvalid = 1'b0;
    logic              m_axi_rready;

    axi4lite_master_param #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          to;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
    } plan_t;

    exp_t        exp_q[$];
    plan_t       slv_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slv_mem[int];
    logic [31:0] exp_last_rd = '0;

    function automatic logic [31:0] dflt(input int a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] slv_rd(input int a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    function automatic plan_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [1:0] r, input int awd,
                                 input int wd, input int ard, input int rd);
        plan_t p;
        p.wr = wr; p.addr = a; p.data = d; p.strb = s; p.resp = r;
        p.aw_dly = awd; p.w_dly = wd; p.ar_dly = ard; p.rsp_dly = rd;
        return p;
    endfunction

    // Issue one request; expected response and slave behaviour are queued at acceptance.
    task automatic issue(input plan_t p, input bit hold, input bit b2b, input bit to_exp);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL req_ready_wait: got 0, expected 1 within 2000 cycles");
            $fatal(1, "request never accepted");
        end
        if (b2b) chk("b2b_accept_on_rsp", rsp_valid, 1'b1);
        req_valid = 1'b1;
        req_write = p.wr;
        req_addr  = p.addr;
        req_wdata = p.data;
        req_wstrb = p.strb;
        e.wr  = p.wr;
        e.acc = cyc;
        e.to  = to_exp;
        if (to_exp) begin
            e.resp  = 2'b10;
            e.rdata = exp_last_rd;
            e.lat   = TO_CYC + 1;
        end else if (p.wr) begin
            e.resp  = p.resp;
            e.rdata = exp_last_rd;
            e.lat   = ((p.aw_dly > p.w_dly) ? p.aw_dly : p.w_dly) + 3 + p.rsp_dly;
            if (!p.resp[1]) ref_mem[int'(p.addr)] = merge(ref_rd(int'(p.addr)), p.data, p.strb);
        end else begin
            e.resp      = p.resp;
            e.rdata     = ref_rd(int'(p.addr));
            exp_last_rd = e.rdata;
            e.lat       = p.ar_dly + 3 + p.rsp_dly;
        end
        slv_q.push_back(p);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_overlap", m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid), 1'b0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 resp=%0d, expected no response", rsp_resp);
                end else begin
                    me = exp_q.pop_front();
                    chk("rsp_resp", rsp_resp, me.resp);
                    chk("rsp_err", rsp_err, me.resp[1]);
                    chk("rsp_timeout", rsp_timeout, me.to);
                    chk("rsp_rdata", rsp_rdata, me.rdata);
                    chk("rsp_latency", 64'(cyc - me.acc), 64'(me.lat));
                end
            end else begin
                chk("rsp_err_unqualified", rsp_err, 1'b0);
            end
        end
    end

    // Slave model: READY after a planned number of VALID cycles, memory-backed reads.
    plan_t       cur;
    bit          cur_vld = 0;
    bit          aw_got, w_got, ar_got;
    int          aw_c, w_c, ar_c, r_c;
    logic [7:0]  cap_addr, cap_araddr;
    logic [31:0] cap_data;
    logic [3:0]  cap_strb;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid  = 1'b0; m_axi_rvalid = 1'b0;
            cur_vld = 0;
        end else begin
            if (!cur_vld && (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid)) begin
                if (slv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL slave_unplanned: got a VALID, expected no transaction");
                end else begin
                    cur = slv_q.pop_front();
                    cur_vld = 1;
                    aw_c = 0; w_c = 0; ar_c = 0; r_c = 0;
                    aw_got = 0; w_got = 0; ar_got = 0;
                    chk("slave_direction", m_axi_awvalid || m_axi_wvalid, cur.wr);
                end
            end
            if (cur_vld) begin
                if (m_axi_awready) begin
                    m_axi_awready = 1'b0; aw_got = 1;
                end else if (m_axi_awvalid && !aw_got) begin
                    if (aw_c >= cur.aw_dly) begin m_axi_awready = 1'b1; cap_addr = m_axi_awaddr; end
                    else aw_c++;
                end
                if (m_axi_wready) begin
                    m_axi_wready = 1'b0; w_got = 1;
                end else if (m_axi_wvalid && !w_got) begin
                    if (w_c >= cur.w_dly) begin
                        m_axi_wready = 1'b1; cap_data = m_axi_wdata; cap_strb = m_axi_wstrb;
                    end else w_c++;
                end
                if (m_axi_arready) begin
                    m_axi_arready = 1'b0; ar_got = 1;
                end else if (m_axi_arvalid && !ar_got) begin
                    if (ar_c >= cur.ar_dly) begin m_axi_arready = 1'b1; cap_araddr = m_axi_araddr; end
                    else ar_c++;
                end
                if (m_axi_bvalid) begin
                    m_axi_bvalid = 1'b0; cur_vld = 0;
                end else if (aw_got && w_got && m_axi_bready) begin
                    if (r_c >= cur.rsp_dly) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = cur.resp;
                        chk("slave_awaddr", cap_addr, cur.addr);
                        chk("slave_wdata", cap_data, cur.data);
                        chk("slave_wstrb", cap_strb, cur.strb);
                        if (!cur.resp[1]) slv_mem[int'(cap_addr)] = merge(slv_rd(int'(cap_addr)), cap_data, cap_strb);
                    end else r_c++;
                end
                if (m_axi_rvalid) begin
                    m_axi_rvalid = 1'b0; cur_vld = 0;
                end else if (ar_got && m_axi_rready) begin
                    if (r_c >= cur.rsp_dly) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = slv_rd(int'(cap_araddr));
                        m_axi_rresp  = cur.resp;
                        chk("slave_araddr", cap_araddr, cur.addr);
                    end else r_c++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no completion, expected finish within 1 ms");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int  n;
        bit  hold;
        plan_t p;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        chk("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;

        // Minimum-latency write
        issue(mk(1, 8'h10, 32'hDEADBEEF, 4'b0101, 2'b00, 0, 0, 0, 0), 0, 0, 0);
        @(negedge clk);
        chk("w1_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        chk("w1_awaddr", m_axi_awaddr, 8'h10);
        chk("w1_wdata", m_axi_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", m_axi_wstrb, 4'b0101);
        @(negedge clk);
        chk("w1_bready", m_axi_bready, 1'b1);
        chk("w1_aw_w_dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
        drain();

        // Skewed write: wready in cycle 2, awready in cycle 5
        issue(mk(1, 8'h20, 32'h0BAD_F00D, 4'hF, 2'b00, 4, 1, 0, 0), 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("skew_c2_wvalid", m_axi_wvalid, 1'b1);
        @(negedge clk);
        chk("skew_c3_wvalid_low", m_axi_wvalid, 1'b0);
        chk("skew_c3_awvalid", m_axi_awvalid, 1'b1);
        chk("skew_c3_awaddr", m_axi_awaddr, 8'h20);
        @(negedge clk);
        @(negedge clk);
        chk("skew_c5_awvalid", m_axi_awvalid, 1'b1);
        chk("skew_c5_awaddr", m_axi_awaddr, 8'h20);
        chk("skew_c5_bready", m_axi_bready, 1'b0);
        @(negedge clk);
        chk("skew_c6_bready", m_axi_bready, 1'b1);
        chk("skew_c6_awvalid_low", m_axi_awvalid, 1'b0);
        drain();

        // Delayed read returning SLVERR
        issue(mk(1, 8'h30, 32'hA5A5_0001, 4'hF, 2'b00, 0, 0, 0, 0), 0, 0, 0);
        drain();
        issue(mk(0, 8'h30, 0, 0, 2'b10, 0, 0, 3, 0), 0, 0, 0);
        drain();
        chk("rd_rdata_held", rsp_rdata, 32'hA5A5_0001);

        // Back-to-back write then read with req_valid held
        issue(mk(1, 8'h31, 32'h1122_3344, 4'b1100, 2'b00, 0, 0, 0, 0), 1, 0, 0);
        issue(mk(0, 8'h31, 0, 0, 2'b01, 0, 0, 0, 0), 0, 1, 0);
        drain();

        // Asynchronous reset while waiting in WR_RESP
        issue(mk(1, 8'h44, 32'h1234_5678, 4'hF, 2'b10, 0, 0, 0, 40), 0, 0, 0);
        n = 0;
        while (!m_axi_bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_bready", m_axi_bready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        chk("rst_mid_readies", {m_axi_bready, m_axi_rready}, 2'b00);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        exp_q.delete();
        slv_q.delete();
        exp_last_rd = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_req_ready", req_ready, 1'b1);
        issue(mk(0, 8'h30, 0, 0, 2'b00, 0, 0, 0, 0), 0, 0, 0);
        drain();

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            p.wr      = 1'($urandom);
            p.addr    = 8'($urandom_range(0, 15));
            p.data    = $urandom;
            p.strb    = 4'($urandom);
            p.resp    = 2'($urandom);
            p.aw_dly  = $urandom_range(0, 3);
            p.w_dly   = $urandom_range(0, 3);
            p.ar_dly  = $urandom_range(0, 3);
            p.rsp_dly = $urandom_range(0, 3);
            hold = (i < 149) && ($urandom_range(0, 1) == 1);
            issue(p, hold, 0, 0);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

`ifdef AXI4L_TIMEOUT_EN
        // Watchdog abort on a read whose arready never arrives
        issue(mk(0, 8'h05, 0, 0, 2'b00, 0, 0, 100000, 0), 0, 0, 1);
        drain();
        chk("to_arvalid_dropped", m_axi_arvalid, 1'b0);
        chk("to_idle", busy, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        slv_q.delete();
        exp_last_rd = '0;
        rst_n = 1'b1;
        issue(mk(0, 8'h10, 0, 0, 2'b00, 0, 0, 0, 0), 0, 0, 0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
